sdram_aref: RTL and testbench



---
 rtl/sdram_aref.sv | 178 +++++++++++++++++
 tb/tb_sdram_aref.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref.sv
// Periodic auto-refresh engine: times the refresh interval, queues pending
// refreshes and, once granted by the arbiter, issues PRECHARGE-all followed
// by AUTO-REFRESH on its own command/address lane.
module sdram_aref #(
    parameter int unsigned ADDR_BITS    = 12,
    parameter int unsigned REF_INTERVAL = 1040,
    parameter int unsigned T_RP         = 3,
    parameter int unsigned T_RFC        = 9,
    parameter int unsigned MAX_PEND     = 8
) (
    input  logic                 sdram_clk,
    input  logic                 rst,
    input  logic                 init_done,
    input  logic                 aref_en,
    output logic                 aref_req,
    output logic                 aref_done,
    output logic                 aref_ovf,
    output logic [3:0]           cmd_reg,
    output logic [ADDR_BITS-1:0] sdram_addr
);

    localparam int unsigned RefW    = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam int unsigned PendW   = $clog2(MAX_PEND + 1);
    localparam int unsigned WaitMax = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int unsigned WaitW   = $clog2(WaitMax + 1);

    localparam logic [RefW-1:0]      RefLast = RefW'(REF_INTERVAL - 1);
    localparam logic [PendW-1:0]     PendMax = PendW'(MAX_PEND);
    localparam logic [PendW-1:0]     PendOne = PendW'(1);
    localparam logic [WaitW-1:0]     RpLoad  = WaitW'(T_RP - 1);
    localparam logic [WaitW-1:0]     RfcLoad = WaitW'(T_RFC - 1);
    localparam logic [WaitW-1:0]     WaitOne = WaitW'(1);
    localparam logic [ADDR_BITS-1:0] AddrA10 = ADDR_BITS'(12'h400);

    // {CS_n, RAS_n, CAS_n, WE_n}
    localparam logic [3:0] CmdNop  = 4'b0111;
    localparam logic [3:0] CmdPre  = 4'b0010;
    localparam logic [3:0] CmdAref = 4'b0001;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StWaitRp,
        StAref,
        StWaitRfc,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [WaitW-1:0]       wait_q, wait_d;
    logic [RefW-1:0]        ref_cnt_q, ref_cnt_d;
    logic [PendW-1:0]       pend_q, pend_d;
    logic                   ovf_q, ovf_d;
    logic                   tick;
    logic                   completing;
    logic [3:0]             cmd_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   done_q;

    assign completing = (state_q == StDone);
    assign aref_req   = (state_q == StIdle) && (pend_q != '0);
    assign aref_done  = done_q;
    assign aref_ovf   = ovf_q;
    assign cmd_reg    = cmd_q;
    assign sdram_addr = addr_q;

    // Free-running interval timer; held at zero until initialization completes.
    always_comb begin
        ref_cnt_d = ref_cnt_q;
        tick      = 1'b0;
        if (!init_done) begin
            ref_cnt_d = '0;
        end else if (ref_cnt_q == RefLast) begin
            ref_cnt_d = '0;
            tick      = 1'b1;
        end else begin
            ref_cnt_d = ref_cnt_q + RefW'(1);
        end
    end

    // Pending-refresh bookkeeping; a tick and a completion in one cycle cancel.
    always_comb begin
        pend_d = pend_q;
        ovf_d  = ovf_q;
        if (!init_done) begin
            pend_d = '0;
        end else if (tick && !completing) begin
            if (pend_q == PendMax) begin
                ovf_d = 1'b1;
            end else begin
                pend_d = pend_q + PendOne;
            end
        end else if (completing && !tick && (pend_q != '0)) begin
            pend_d = pend_q - PendOne;
        end
    end

    // Sequence next-state; the shared wait counter is loaded on entry to each wait state.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (aref_req && aref_en) begin
                    state_d = StPre;
                end
            end
            StPre: begin
                if (T_RP > 1) begin
                    state_d = StWaitRp;
                    wait_d  = RpLoad;
                end else begin
                    state_d = StAref;
                end
            end
            StWaitRp: begin
                if (wait_q <= WaitOne) begin
                    state_d = StAref;
                end else begin
                    wait_d = wait_q - WaitOne;
                end
            end
            StAref: begin
                if (T_RFC > 1) begin
                    state_d = StWaitRfc;
                    wait_d  = RfcLoad;
                end else begin
                    state_d = StDone;
                end
            end
            StWaitRfc: begin
                if (wait_q <= WaitOne) begin
                    state_d = StDone;
                end else begin
                    wait_d = wait_q - WaitOne;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Timer, pending count and sticky overflow registers.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            ref_cnt_q <= '0;
            pend_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
        end
    end

    // FSM state plus outputs decoded from the next state so they align with it.
    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
            cmd_q   <= CmdNop;
            addr_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            cmd_q   <= (state_d == StPre)  ? CmdPre  :
                       (state_d == StAref) ? CmdAref : CmdNop;
            addr_q  <= (state_d == StPre) ? AddrA10 : '0;
            done_q  <= (state_d == StDone);
        end
    end

endmodule

// File: tb/tb_sdram_aref.sv
// Bench for sdram_aref: a sequence-offset model of the refresh engine is
// compared against the DUT every cycle, plus literal timing expectations.
module tb_sdram_aref;

    localparam int RI      = 1040;
    localparam int TRP     = 3;
    localparam int TRFC    = 9;
    localparam int MAXP    = 8;
    localparam int SEQ_LEN = TRP + TRFC + 1;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        init_done = 1'b0;
    logic        aref_en   = 1'b0;
    logic        aref_req;
    logic        aref_done;
    logic        aref_ovf;
    logic [3:0]  cmd_reg;
    logic [11:0] sdram_addr;

    always #5 clk = ~clk;

    sdram_aref #(
        .ADDR_BITS    (12),
        .REF_INTERVAL (RI),
        .T_RP         (TRP),
        .T_RFC        (TRFC),
        .MAX_PEND     (MAXP)
    ) dut (
        .sdram_clk  (clk),
        .rst        (rst),
        .init_done  (init_done),
        .aref_en    (aref_en),
        .aref_req   (aref_req),
        .aref_done  (aref_done),
        .aref_ovf   (aref_ovf),
        .cmd_reg    (cmd_reg),
        .sdram_addr (sdram_addr)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Model: init-cycle count, pending refreshes, sticky overflow and the
    // position inside a running sequence (0 = idle, 1..SEQ_LEN otherwise).
    int m_cnt  = 0;
    int m_pend = 0;
    int m_off  = 0;
    bit m_ovf  = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model update on every rising edge from the pre-edge inputs.
    initial forever begin
        bit tick, comp, req;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_cnt  = 0;
            m_pend = 0;
            m_off  = 0;
            m_ovf  = 1'b0;
        end else begin
            tick  = init_done && (m_cnt == RI - 1);
            comp  = (m_off == SEQ_LEN);
            req   = (m_off == 0) && (m_pend != 0);
            m_cnt = init_done ? (m_cnt + 1) % RI : 0;
            if (!init_done) begin
                m_pend = 0;
            end else if (tick && !comp) begin
                if (m_pend == MAXP) m_ovf = 1'b1;
                else m_pend = m_pend + 1;
            end else if (comp && !tick && m_pend > 0) begin
                m_pend = m_pend - 1;
            end
            if (m_off == 0) m_off = (req && aref_en) ? 1 : 0;
            else if (m_off == SEQ_LEN) m_off = 0;
            else m_off = m_off + 1;
        end
    end

    // Compare every cycle on the falling edge.
    initial forever begin
        logic [3:0]  e_cmd;
        logic [11:0] e_addr;
        @(negedge clk);
        if (chk_en) begin
            e_cmd  = (m_off == 1) ? 4'b0010 : (m_off == 1 + TRP) ? 4'b0001 : 4'b0111;
            e_addr = (m_off == 1) ? 12'h400 : 12'h000;
            check("aref_req", 32'(aref_req), 32'((m_off == 0) && (m_pend != 0)));
            check("cmd_reg", 32'(cmd_reg), 32'(e_cmd));
            check("sdram_addr", 32'(sdram_addr), 32'(e_addr));
            check("aref_done", 32'(aref_done), 32'(m_off == SEQ_LEN));
            check("aref_ovf", 32'(aref_ovf), 32'(m_ovf));
        end
    end

    // Wait (bounded) for an event observed on the falling edge; returns its cycle.
    task automatic wait_ev(input int kind, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if ((kind == 0 && aref_req === 1'b1) || (kind == 1 && cmd_reg === 4'b0010) ||
                (kind == 2 && cmd_reg === 4'b0001) || (kind == 3 && aref_done === 1'b1)) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) check($sformatf("timeout_kind%0d", kind), 0, 1);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, at, a, k, t0, t1, g, nd;
        int dq[$];

        // Reset, then a long stretch with initialization still pending.
        next_cycle();
        chk_en = 1'b1;
        repeat (4) next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("reset_cmd", 32'(cmd_reg), 32'h7);
        check("reset_req", 32'(aref_req), 32'h0);
        repeat (5000) next_cycle();
        @(negedge clk);
        check("preinit_req", 32'(aref_req), 32'h0);

        // Init rises with the grant tied high: first sequence timing.
        next_cycle();
        init_done = 1'b1;
        aref_en   = 1'b1;
        t = cyc;
        wait_ev(0, 1100, at);  check("first_req_cycle", at, t + 1040);
        wait_ev(1, 5, at);     check("pre_cycle", at, t + 1041);
        check("pre_addr", 32'(sdram_addr), 32'h400);
        wait_ev(2, 10, at);    check("aref_cycle", at, t + 1044);
        wait_ev(3, 20, at);    check("done_cycle", at, t + 1053);
        wait_ev(0, 1100, at);  check("second_req_cycle", at, t + 2080);
        wait_ev(3, 20, at);    check("second_done_cycle", at, t + 2093);

        // Three intervals without a grant, then back-to-back sequences.
        next_cycle();
        aref_en = 1'b0;
        repeat (3 * RI) @(posedge clk);
        #1;
        check("model_pend_3", m_pend, 3);
        @(negedge clk);
        check("req_pending", 32'(aref_req), 32'h1);
        next_cycle();
        aref_en = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (aref_done === 1'b1) dq.push_back(cyc);
        end
        check("burst_done_count", dq.size(), 3);
        check("burst_gap1", (dq.size() >= 2) ? dq[1] - dq[0] : -1, 14);
        check("burst_gap2", (dq.size() >= 3) ? dq[2] - dq[1] : -1, 14);
        check("burst_req_low", 32'(aref_req), 32'h0);

        // Nine intervals without a grant: saturation and sticky overflow.
        next_cycle();
        aref_en = 1'b0;
        repeat (9 * RI) @(posedge clk);
        #1;
        check("model_pend_sat", m_pend, 8);
        @(negedge clk);
        check("ovf_set", 32'(aref_ovf), 32'h1);
        next_cycle();
        aref_en = 1'b1;
        nd = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (aref_done === 1'b1) nd++;
        end
        check("drain_done_count", nd, 8);
        check("ovf_sticky", 32'(aref_ovf), 32'h1);
        check("drained_req_low", 32'(aref_req), 32'h0);

        // Tick coinciding with the DONE cycle while one refresh is pending.
        next_cycle();
        aref_en = 1'b0;
        k = 1;
        while (t + RI * k - 1 <= cyc + 2) k++;
        t0 = t + RI * k - 1;
        t1 = t0 + RI;
        g  = t1 - 13;
        while (cyc < g - 1) next_cycle();
        next_cycle();
        aref_en = 1'b1;
        next_cycle();
        aref_en = 1'b0;
        wait_ev(3, 20, at);    check("aligned_done_cycle", at, t1);
        @(negedge clk);
        check("aligned_req", 32'(aref_req), 32'h1);
        check("model_pend_aligned", m_pend, 1);

        // Reset in the middle of the tRFC wait.
        next_cycle();
        aref_en = 1'b1;
        wait_ev(2, 10, a);
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        aref_en = 1'b0;
        @(negedge clk);
        check("rst_req", 32'(aref_req), 32'h0);
        check("rst_cmd", 32'(cmd_reg), 32'h7);
        check("rst_addr", 32'(sdram_addr), 32'h0);
        check("rst_done", 32'(aref_done), 32'h0);
        check("rst_ovf", 32'(aref_ovf), 32'h0);
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (aref_done === 1'b1) nd++;
        end
        check("rst_no_done", nd, 0);

        // Randomized grants with occasional initialization drops.
        for (int i = 0; i < 12000; i++) begin
            next_cycle();
            aref_en = ($urandom % 4) == 0;
            if (init_done && ($urandom % 3000) == 0) init_done = 1'b0;
            else if (!init_done && ($urandom % 20) == 0) init_done = 1'b1;
        end
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
